// File: rtl/homo_pkg.sv
// homo_pkg: gain constants and width helpers shared by the homomorphic filter blocks
package homo_pkg;
  localparam logic [7:0] GAIN_ONE = 8'h10;
  localparam int GAIN_SH = 4;
  function automatic int log_w(input int data_w, input int frac_w);
    return $clog2(data_w) + frac_w;
  endfunction
  function automatic int ch_w(input int num_ch);
    return num_ch > 1 ? $clog2(num_ch) : 1;
  endfunction
  function automatic int sat_max(input int data_w, input int frac_w);
    return ((data_w - 1) << frac_w) | ((1 << frac_w) - 1);
  endfunction
endpackage

// File: rtl/homo_log2.sv
// homo_log2: combinational Mitchell log2 (leading-one index plus MSB-aligned mantissa)
module homo_log2 import homo_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  localparam int LW = log_w(DATA_W, FRAC_W)
) (
  input  logic [DATA_W-1:0] x,
  output logic              zero,
  output logic [LW-1:0]     l
);
  localparam int PW = $clog2(DATA_W);
  logic [PW-1:0] p;
  always_comb begin
    p = '0;
    for (int i = 0; i < DATA_W; i++) p = x[i] ? PW'(i) : p;
  end
  assign zero = x == '0;
  assign l = {p, FRAC_W'((x << (PW'(DATA_W - 1) - p)) >> (DATA_W - 1 - FRAC_W))};
endmodule

// File: rtl/homomorphic_mc.sv
// homomorphic_mc: multi-channel log2 / log-domain emphasis filter / exp2 pipeline with valid-ready
module homomorphic_mc import homo_pkg::*; #(
  parameter int          DATA_W   = 32,
  parameter int          FRAC_W   = 8,
  parameter int          NUM_CH   = 4,
  parameter int          ALPHA_SH = 3,
  parameter logic [7:0]  GAMMA_H  = 8'h18,
  parameter logic [7:0]  GAMMA_L  = 8'h08,
  localparam int         CH_W     = ch_w(NUM_CH),
  localparam int         LW       = log_w(DATA_W, FRAC_W)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] input_data,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              in_bypass,
  input  logic              flush,
  output logic [DATA_W-1:0] output_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              write_enable,
  input  logic              out_ready
);
  localparam int SW = LW + 1;
  localparam int PW = LW + 12;
  localparam int EW = DATA_W + FRAC_W + 1;
  localparam logic [LW-1:0] Y_MAX = LW'(sat_max(DATA_W, FRAC_W));
  localparam logic signed [PW-1:0] ACC_MAX = PW'(sat_max(DATA_W, FRAC_W));
  logic adv, accept, byp_in, rmw;
  logic v1, v2, v3;
  logic [DATA_W-1:0] raw1, raw2, raw3;
  logic [CH_W-1:0] ch1, ch2, ch3;
  logic byp1, byp2, byp3, z1, z2, z3;
  logic [LW-1:0] l1, y, y3;
  logic signed [SW-1:0] lp [NUM_CH];
  logic [NUM_CH-1:0] primed;
  logic signed [SW-1:0] l_ext, lp_old, d, lp_new, d2, lp2;
  logic signed [PW-1:0] acc;
  logic [EW-1:0] e;
  logic [DATA_W-1:0] ex;
  assign adv = !write_enable || out_ready;
  assign in_ready = adv && RST;
  assign accept = in_valid && in_ready;
  assign byp_in = in_bypass || 32'(in_ch) >= NUM_CH;
  homo_log2 #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_log (.x(raw1), .zero(z1), .l(l1));
  assign l_ext = signed'({1'b0, l1});
  assign lp_old = primed[ch1] ? lp[ch1] : l_ext;
  assign d = l_ext - lp_old;
  assign lp_new = lp_old + (d >>> ALPHA_SH);
  assign rmw = adv && v1 && !z1 && !byp1;
  assign acc = (signed'(PW'({1'b0, GAMMA_H})) * PW'(d2) + signed'(PW'({1'b0, GAMMA_L})) * PW'(lp2)) >>> GAIN_SH;
  assign y = acc[PW-1] ? '0 : acc > ACC_MAX ? Y_MAX : acc[LW-1:0];
  assign e = EW'({1'b1, y3[FRAC_W-1:0]}) << y3[LW-1:FRAC_W] >> FRAC_W;
  assign ex = |e[EW-1:DATA_W] ? '1 : e[DATA_W-1:0];
  always_ff @(posedge CLK) begin
    if (!RST) begin
      {v1, v2, v3, write_enable} <= '0;
      output_data <= '0;
      out_ch <= '0;
      primed <= '0;
    end else begin
      if (adv) begin
        {v1, v2, v3, write_enable} <= {accept, v1, v2, v3};
        {raw1, ch1, byp1} <= {input_data, in_ch, byp_in};
        {raw2, ch2, byp2, z2, d2, lp2} <= {raw1, ch1, byp1, z1, d, lp_old};
        {raw3, ch3, byp3, z3, y3} <= {raw2, ch2, byp2, z2, y};
        if (v3) begin
          output_data <= z3 ? '0 : byp3 ? raw3 : ex;
          out_ch <= ch3;
        end
      end
      if (flush) primed <= '0;
      else if (rmw) begin
        primed[ch1] <= 1'b1;
        lp[ch1] <= lp_new;
      end
    end
  end
endmodule
